inst_queue: RTL

//  2-wide instruction queue directly downstream of the PC/fetch stage.
//  - Each cycle the fetch path offers one aligned pair of instructions, fetched at pc and pc+4.
//  - The queue buffers the pairs in order and presents up to two head entries to dispatch.
//  - It produces iq_full/iq_empty, which the PC controller uses to stall or advance pc by 8.

---
 rtl/inst_queue_if.sv | 38 +++
 rtl/inst_queue.sv | 85 ++++++++
 2 files changed

// File: rtl/inst_queue_if.sv
// Fetch-to-dispatch bundle for the 2-wide instruction queue.
// The slave side is the queue; the master side is the fetch/dispatch environment.
interface inst_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_valid1;
  logic [ADDR_W-1:0] in_pc;
  logic [DATA_W-1:0] in_inst0;
  logic [DATA_W-1:0] in_inst1;
  logic [1:0]        deq_num;
  logic              out_valid0;
  logic              out_valid1;
  logic [DATA_W-1:0] out_inst0;
  logic [DATA_W-1:0] out_inst1;
  logic [ADDR_W-1:0] out_pc0;
  logic [ADDR_W-1:0] out_pc1;
  logic              iq_full;
  logic              iq_empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, in_valid, in_valid1, in_pc, in_inst0, in_inst1, deq_num,
    input  out_valid0, out_valid1, out_inst0, out_inst1, out_pc0, out_pc1,
           iq_full, iq_empty, count
  );

  modport slave (
    input  flush, in_valid, in_valid1, in_pc, in_inst0, in_inst1, deq_num,
    output out_valid0, out_valid1, out_inst0, out_inst1, out_pc0, out_pc1,
           iq_full, iq_empty, count
  );
endinterface

// File: rtl/inst_queue.sv
// 2-wide in-order instruction queue between fetch and dispatch.
// Full/empty come from the registered count, so a same-cycle pop never unblocks a push.
module inst_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input logic         clk,
  input logic         rst,
  inst_queue_if.slave q
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;

  logic             full;
  logic             empty;
  logic             push_ok;
  logic [1:0]       pushed;
  logic [1:0]       deq_eff;
  logic [1:0]       popped;
  logic [PTR_W-1:0] head1;
  logic [PTR_W-1:0] tail1;

  always_comb begin
    full    = cnt >= CNT_W'(DEPTH - 1);
    empty   = cnt == '0;
    push_ok = q.in_valid && !full && !q.flush;
    pushed  = '0;
    if (push_ok)
      pushed = q.in_valid1 ? 2'd2 : 2'd1;
    deq_eff = (q.deq_num == 2'd3) ? 2'd2 : q.deq_num;
    // Pops are bounded by the pre-push count: same-cycle pushes are not visible yet.
    popped  = deq_eff;
    if (CNT_W'(deq_eff) > cnt)
      popped = cnt[1:0];
    head1   = head + PTR_W'(1);
    tail1   = tail + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PTR_W'(popped);
      tail <= tail + PTR_W'(pushed);
      cnt  <= cnt + CNT_W'(pushed) - CNT_W'(popped);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      inst_mem[tail] <= q.in_inst0;
      pc_mem[tail]   <= q.in_pc;
      if (q.in_valid1) begin
        inst_mem[tail1] <= q.in_inst1;
        pc_mem[tail1]   <= q.in_pc + ADDR_W'(4);
      end
    end
  end

  always_comb begin
    q.out_valid0 = cnt >= CNT_W'(1);
    q.out_valid1 = cnt >= CNT_W'(2);
    q.out_inst0  = q.out_valid0 ? inst_mem[head]  : '0;
    q.out_pc0    = q.out_valid0 ? pc_mem[head]    : '0;
    q.out_inst1  = q.out_valid1 ? inst_mem[head1] : '0;
    q.out_pc1    = q.out_valid1 ? pc_mem[head1]   : '0;
    q.iq_full    = full;
    q.iq_empty   = empty;
    q.count      = cnt;
  end
endmodule
